// File: rtl/comp_nbit_pipe.sv
// Pipelined N-bit magnitude comparator built from 2-bit less/equal cells.
// Supports unsigned, two's-complement and sign-magnitude compares. A sideband
// tag travels with each beat through a valid/ready pipeline of STAGES registers.
module comp_nbit_pipe #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2,
  parameter int TAG_W  = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_data_a,
  input  logic [WIDTH-1:0] i_data_b,
  input  logic [1:0]       i_mode,
  input  logic [TAG_W-1:0] i_tag,
  output logic             o_valid,
  input  logic             i_ready,
  output logic             o_less,
  output logic             o_equal,
  output logic             o_greater,
  output logic [TAG_W-1:0] o_tag
);

  localparam int NL = WIDTH / 2;
  localparam int NP = 1 << $clog2(NL);

  typedef enum logic [1:0] {
    MODE_UNS     = 2'b00,
    MODE_SIGNED  = 2'b01,
    MODE_SIGNMAG = 2'b10,
    MODE_UNS_ALT = 2'b11
  } mode_e;

  // Reduces per-slice (lt,eq) pairs as a balanced tree. The slice vector is
  // padded above the MSB with neutral (lt=0,eq=1) cells so any slice count works.
  function automatic logic [1:0] mergeTree(input logic [NL-1:0] lt, input logic [NL-1:0] eq);
    logic [NP-1:0] l;
    logic [NP-1:0] e;
    l = '0;
    e = '1;
    l[NL-1:0] = lt;
    e[NL-1:0] = eq;
    for (int w = NP / 2; w >= 1; w = w / 2) begin
      for (int i = 0; i < w; i++) begin
        l[i] = l[2*i+1] | (e[2*i+1] & l[2*i]);
        e[i] = e[2*i+1] & e[2*i];
      end
    end
    return {l[0], e[0]};
  endfunction

  logic [NL-1:0]     fullLt_d, fullEq_d, magLt_d, magEq_d;
  logic [WIDTH-1:0]  magA, magB;
  logic              bothZero_d;

  logic [NL-1:0]     fullLt_q, fullEq_q, magLt_q, magEq_q;
  logic              signA_q, signB_q, bothZero_q;
  mode_e             mode_q;
  logic [TAG_W-1:0]  tag0_q;

  logic [STAGES-1:0] valid_q;
  logic [STAGES-1:0] validIn;
  logic [STAGES-1:0] load;

  logic [1:0]        fullRes, magRes;
  logic              decLt, decEq;
  logic              resLt, resEq;
  logic [TAG_W-1:0]  resTag;

  // Leaf cells: 2-bit lt/eq for the full words and for the sign-stripped magnitudes.
  always_comb begin
    magA       = {1'b0, i_data_a[WIDTH-2:0]};
    magB       = {1'b0, i_data_b[WIDTH-2:0]};
    fullLt_d   = '0;
    fullEq_d   = '0;
    magLt_d    = '0;
    magEq_d    = '0;
    for (int i = 0; i < NL; i++) begin
      fullLt_d[i] = i_data_a[2*i +: 2] <  i_data_b[2*i +: 2];
      fullEq_d[i] = i_data_a[2*i +: 2] == i_data_b[2*i +: 2];
      magLt_d[i]  = magA[2*i +: 2] <  magB[2*i +: 2];
      magEq_d[i]  = magA[2*i +: 2] == magB[2*i +: 2];
    end
    bothZero_d = (magA == '0) && (magB == '0);
  end

  // Stage s may load when every stage from s to the output has a hole or the sink drains.
  always_comb begin
    logic acc;
    load = '0;
    for (int s = 0; s < STAGES; s++) begin
      acc = i_ready;
      for (int j = s; j < STAGES; j++) begin
        acc = acc | !valid_q[j];
      end
      load[s] = acc;
    end
  end

  assign o_ready = load[0];

  if (STAGES == 1) begin : gVin1
    assign validIn = i_valid;
  end else begin : gVinN
    assign validIn = {valid_q[STAGES-2:0], i_valid};
  end

  // Stage valid bits: cleared by reset, shifted forward wherever a stage loads.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      valid_q <= '0;
    end else begin
      for (int s = 0; s < STAGES; s++) begin
        if (load[s]) valid_q[s] <= validIn[s];
      end
    end
  end

  // Stage 0 captures the leaf results, sign bits, mode and tag of an accepted beat.
  always_ff @(posedge i_clk) begin
    if (load[0]) begin
      fullLt_q   <= fullLt_d;
      fullEq_q   <= fullEq_d;
      magLt_q    <= magLt_d;
      magEq_q    <= magEq_d;
      signA_q    <= i_data_a[WIDTH-1];
      signB_q    <= i_data_b[WIDTH-1];
      bothZero_q <= bothZero_d;
      mode_q     <= mode_e'(i_mode);
      tag0_q     <= i_tag;
    end
  end

  // Finish the trees and apply the mode rules to get the final less/equal decision.
  always_comb begin
    fullRes = mergeTree(fullLt_q, fullEq_q);
    magRes  = mergeTree(magLt_q, magEq_q);
    decLt   = fullRes[1];
    decEq   = fullRes[0];
    case (mode_q)
      MODE_SIGNED: begin
        if (signA_q != signB_q) begin
          decLt = signA_q;
          decEq = 1'b0;
        end
      end
      MODE_SIGNMAG: begin
        if (bothZero_q) begin
          decLt = 1'b0;
          decEq = 1'b1;
        end else if (signA_q != signB_q) begin
          decLt = signA_q;
          decEq = 1'b0;
        end else if (!signA_q) begin
          decLt = magRes[1];
          decEq = magRes[0];
        end else begin
          decLt = !magRes[1] && !magRes[0];
          decEq = magRes[0];
        end
      end
      default: begin
      end
    endcase
  end

  if (STAGES > 1) begin : gPipe
    logic             ltQ  [STAGES-1];
    logic             eqQ  [STAGES-1];
    logic [TAG_W-1:0] tagQ [STAGES-1];

    // Later stages just carry the decided result and tag toward the output.
    always_ff @(posedge i_clk) begin
      if (load[1]) begin
        ltQ[0]  <= decLt;
        eqQ[0]  <= decEq;
        tagQ[0] <= tag0_q;
      end
      for (int p = 1; p < STAGES - 1; p++) begin
        if (load[p+1]) begin
          ltQ[p]  <= ltQ[p-1];
          eqQ[p]  <= eqQ[p-1];
          tagQ[p] <= tagQ[p-1];
        end
      end
    end

    assign resLt  = ltQ[STAGES-2];
    assign resEq  = eqQ[STAGES-2];
    assign resTag = tagQ[STAGES-2];
  end else begin : gNoPipe
    assign resLt  = decLt;
    assign resEq  = decEq;
    assign resTag = tag0_q;
  end

  assign o_valid   = valid_q[STAGES-1];
  assign o_less    = o_valid & resLt;
  assign o_equal   = o_valid & resEq;
  assign o_greater = o_valid & ~resLt & ~resEq;
  assign o_tag     = o_valid ? resTag : '0;

endmodule

// File: tb/tb_comp_nbit_pipe.sv
// Self-checking bench for comp_nbit_pipe: directed table, hand-written latency,
// reset and backpressure sequences, random streaming and an exhaustive 4-bit sweep.
module tb_comp_nbit_pipe;

  logic clk = 1'b0;
  logic rstN;

  always #5 clk = ~clk;

  logic       mValid, mReadyOut, mReadyIn;
  logic [7:0] mA, mB;
  logic [1:0] mMode;
  logic [3:0] mTag;
  logic       mOValid, mLess, mEqual, mGreater;
  logic [3:0] mOTag;

  logic       sValid [2];
  logic       sReadyOut [2];
  logic       sReadyIn [2];
  logic [3:0] sA [2];
  logic [3:0] sB [2];
  logic [1:0] sMode [2];
  logic [3:0] sTag [2];
  logic       sOValid [2];
  logic       sLess [2];
  logic       sEqual [2];
  logic       sGreater [2];
  logic [3:0] sOTag [2];

  int checks = 0;
  int errors = 0;

  comp_nbit_pipe #(.WIDTH(8), .STAGES(2), .TAG_W(4)) dut (
    .i_clk(clk), .i_rst_n(rstN), .i_valid(mValid), .o_ready(mReadyOut),
    .i_data_a(mA), .i_data_b(mB), .i_mode(mMode), .i_tag(mTag),
    .o_valid(mOValid), .i_ready(mReadyIn), .o_less(mLess), .o_equal(mEqual),
    .o_greater(mGreater), .o_tag(mOTag)
  );

  comp_nbit_pipe #(.WIDTH(4), .STAGES(1), .TAG_W(4)) dutW4S1 (
    .i_clk(clk), .i_rst_n(rstN), .i_valid(sValid[0]), .o_ready(sReadyOut[0]),
    .i_data_a(sA[0]), .i_data_b(sB[0]), .i_mode(sMode[0]), .i_tag(sTag[0]),
    .o_valid(sOValid[0]), .i_ready(sReadyIn[0]), .o_less(sLess[0]), .o_equal(sEqual[0]),
    .o_greater(sGreater[0]), .o_tag(sOTag[0])
  );

  comp_nbit_pipe #(.WIDTH(4), .STAGES(2), .TAG_W(4)) dutW4S2 (
    .i_clk(clk), .i_rst_n(rstN), .i_valid(sValid[1]), .o_ready(sReadyOut[1]),
    .i_data_a(sA[1]), .i_data_b(sB[1]), .i_mode(sMode[1]), .i_tag(sTag[1]),
    .o_valid(sOValid[1]), .i_ready(sReadyIn[1]), .o_less(sLess[1]), .o_equal(sEqual[1]),
    .o_greater(sGreater[1]), .o_tag(sOTag[1])
  );

  // Reference: map each operand to a signed integer value per mode, then compare.
  function automatic logic [2:0] refFlags(input int a, input int b, input int mode, input int w);
    int half, va, vb, ma, mb;
    half = 1 << (w - 1);
    if (mode == 1) begin
      va = (a >= half) ? a - 2 * half : a;
      vb = (b >= half) ? b - 2 * half : b;
    end else if (mode == 2) begin
      ma = a % half;
      mb = b % half;
      va = (a >= half) ? -ma : ma;
      vb = (b >= half) ? -mb : mb;
    end else begin
      va = a;
      vb = b;
    end
    if (va < vb) return 3'b100;
    if (va == vb) return 3'b010;
    return 3'b001;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Offers one beat on the 8-bit DUT and waits (bounded) until it is accepted.
  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b,
                               input logic [1:0] mode, input logic [3:0] tag);
    int guard;
    bit acc;
    mValid = 1'b1;
    mA = a;
    mB = b;
    mMode = mode;
    mTag = tag;
    guard = 0;
    acc = 1'b0;
    while (!acc && guard < 100) begin
      @(negedge clk);
      acc = mReadyOut;
      @(posedge clk);
      #1;
      guard++;
    end
    if (!acc) checkOutput("apply_timeout", 0, 1);
    mValid = 1'b0;
  endtask

  // Exhaustive all-pairs/all-modes stream into one of the 4-bit instances.
  task automatic runSweep(input int k);
    int guard;
    int cnt;
    bit acc;
    cnt = 0;
    for (int m = 0; m < 4; m++) begin
      for (int a = 0; a < 16; a++) begin
        for (int b = 0; b < 16; b++) begin
          sValid[k] = 1'b1;
          sA[k] = 4'(a);
          sB[k] = 4'(b);
          sMode[k] = 2'(m);
          sTag[k] = 4'(cnt);
          cnt++;
          guard = 0;
          acc = 1'b0;
          while (!acc && guard < 60) begin
            sReadyIn[k] = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            acc = sReadyOut[k];
            @(posedge clk);
            #1;
            guard++;
          end
          if (!acc) begin
            checkOutput("sweep_timeout", 0, 1);
            sValid[k] = 1'b0;
            return;
          end
        end
      end
    end
    sValid[k] = 1'b0;
    sReadyIn[k] = 1'b1;
    repeat (6) tick();
  endtask

  logic [6:0] mainQ [$];
  logic [6:0] sweepQ0 [$];
  logic [6:0] sweepQ1 [$];
  logic [6:0] mExp, sExp;
  bit         mainMon = 1'b0;

  // Scoreboard for the random phase on the 8-bit DUT.
  always @(negedge clk) begin
    if (mainMon) begin
      if (mOValid) checkOutput("main_onehot", $countones({mLess, mEqual, mGreater}), 1);
      if (mOValid && mReadyIn) begin
        if (mainQ.size() == 0) begin
          checkOutput("main_unexpected_beat", 1, 0);
        end else begin
          mExp = mainQ.pop_front();
          checkOutput("main_result", {mOTag, mLess, mEqual, mGreater}, mExp);
        end
      end
      if (mValid && mReadyOut) mainQ.push_back({mTag, refFlags(mA, mB, mMode, 8)});
    end
  end

  // Scoreboards for both 4-bit sweep instances.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (sOValid[k]) checkOutput("sweep_onehot", $countones({sLess[k], sEqual[k], sGreater[k]}), 1);
      if (sOValid[k] && sReadyIn[k]) begin
        if ((k == 0 && sweepQ0.size() == 0) || (k == 1 && sweepQ1.size() == 0)) begin
          checkOutput("sweep_unexpected_beat", 1, 0);
        end else begin
          sExp = (k == 0) ? sweepQ0.pop_front() : sweepQ1.pop_front();
          checkOutput(k == 0 ? "sweep_s1_result" : "sweep_s2_result",
                      {sOTag[k], sLess[k], sEqual[k], sGreater[k]}, sExp);
        end
      end
      if (sValid[k] && sReadyOut[k]) begin
        if (k == 0) sweepQ0.push_back({sTag[k], refFlags(sA[k], sB[k], sMode[k], 4)});
        else        sweepQ1.push_back({sTag[k], refFlags(sA[k], sB[k], sMode[k], 4)});
      end
    end
  end

  // Global time bound so the run can never hang.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic [1:0] mode;
    logic [2:0] expFlags;
  } vec_t;

  localparam int NV = 19;
  vec_t vecs [NV];

  int  rxCount;
  bit  sawNotReady;
  bit  prevStall;
  logic [7:0] prevOut;

  initial begin
    vecs[0]  = '{8'h7F, 8'h80, 2'b00, 3'b100};
    vecs[1]  = '{8'h80, 8'h7F, 2'b00, 3'b001};
    vecs[2]  = '{8'hA5, 8'hA5, 2'b00, 3'b010};
    vecs[3]  = '{8'h00, 8'hFF, 2'b00, 3'b100};
    vecs[4]  = '{8'hFF, 8'hFF, 2'b00, 3'b010};
    vecs[5]  = '{8'h80, 8'h7F, 2'b01, 3'b100};
    vecs[6]  = '{8'hFF, 8'hFE, 2'b01, 3'b001};
    vecs[7]  = '{8'h7F, 8'h80, 2'b01, 3'b001};
    vecs[8]  = '{8'hFF, 8'hFF, 2'b01, 3'b010};
    vecs[9]  = '{8'h01, 8'hFF, 2'b01, 3'b001};
    vecs[10] = '{8'h80, 8'h00, 2'b10, 3'b010};
    vecs[11] = '{8'h83, 8'h81, 2'b10, 3'b100};
    vecs[12] = '{8'h01, 8'h81, 2'b10, 3'b001};
    vecs[13] = '{8'h00, 8'h80, 2'b10, 3'b010};
    vecs[14] = '{8'h85, 8'h03, 2'b10, 3'b100};
    vecs[15] = '{8'h05, 8'h06, 2'b10, 3'b100};
    vecs[16] = '{8'h86, 8'h85, 2'b10, 3'b100};
    vecs[17] = '{8'h80, 8'h7F, 2'b11, 3'b001};
    vecs[18] = '{8'h7F, 8'h80, 2'b11, 3'b100};

    rstN = 1'b0;
    mValid = 1'b0;
    mReadyIn = 1'b0;
    mA = '0;
    mB = '0;
    mMode = '0;
    mTag = '0;
    for (int k = 0; k < 2; k++) begin
      sValid[k] = 1'b0;
      sReadyIn[k] = 1'b1;
      sA[k] = '0;
      sB[k] = '0;
      sMode[k] = '0;
      sTag[k] = '0;
    end

    #12;
    checkOutput("reset_outputs", {mOValid, mLess, mEqual, mGreater, mOTag}, 8'h00);
    checkOutput("reset_ready", mReadyOut, 1);
    checkOutput("reset_sweep_valid", {sOValid[0], sOValid[1]}, 0);
    @(posedge clk);
    #1;
    rstN = 1'b1;
    mReadyIn = 1'b1;
    tick();

    // Reset while three beats are in flight.
    mValid = 1'b1; mMode = 2'b00; mA = 8'h01; mB = 8'h02; mTag = 4'h1;
    tick();
    mA = 8'h02; mTag = 4'h2;
    tick();
    mA = 8'h03; mTag = 4'h3;
    tick();
    mValid = 1'b0;
    checkOutput("rst_mid_valid_before", mOValid, 1);
    rstN = 1'b0;
    #1;
    checkOutput("rst_mid_outputs", {mOValid, mLess, mEqual, mGreater, mOTag}, 8'h00);
    checkOutput("rst_mid_ready", mReadyOut, 1);
    #1;
    rstN = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checkOutput("rst_mid_no_output", mOValid, 0);
    end
    checkOutput("rst_mid_ready_after", mReadyOut, 1);

    // Unsigned streaming with exact latency.
    mValid = 1'b1; mMode = 2'b00; mA = 8'h7F; mB = 8'h80; mTag = 4'h0;
    tick();
    checkOutput("stream_latency", mOValid, 0);
    mA = 8'h80; mB = 8'h7F; mTag = 4'h1;
    tick();
    checkOutput("stream_beat0", {mOValid, mLess, mEqual, mGreater, mOTag}, {4'b1100, 4'h0});
    mA = 8'hA5; mB = 8'hA5; mTag = 4'h2;
    tick();
    mValid = 1'b0;
    checkOutput("stream_beat1", {mOValid, mLess, mEqual, mGreater, mOTag}, {4'b1001, 4'h1});
    tick();
    checkOutput("stream_beat2", {mOValid, mLess, mEqual, mGreater, mOTag}, {4'b1010, 4'h2});
    tick();
    checkOutput("stream_empty", mOValid, 0);

    // Directed vector table, one beat at a time.
    for (int i = 0; i < NV; i++) begin
      mValid = 1'b1;
      mA = vecs[i].a;
      mB = vecs[i].b;
      mMode = vecs[i].mode;
      mTag = 4'(i);
      checkOutput("tbl_ready", mReadyOut, 1);
      tick();
      mValid = 1'b0;
      checkOutput("tbl_latency", mOValid, 0);
      tick();
      checkOutput("tbl_result", {mOValid, mLess, mEqual, mGreater, mOTag},
                  {1'b1, vecs[i].expFlags, 4'(i)});
      tick();
    end

    // Backpressure: six tagged beats with a four-cycle stall mid-stream.
    rxCount = 0;
    sawNotReady = 1'b0;
    prevStall = 1'b0;
    prevOut = '0;
    fork
      begin
        for (int t = 0; t < 6; t++) applyStimulus(8'(t), 8'h03, 2'b00, 4'(t));
      end
      begin
        for (int c = 0; c < 30; c++) begin
          mReadyIn = !(c >= 3 && c < 7);
          @(negedge clk);
          if (!mReadyOut) sawNotReady = 1'b1;
          if (prevStall) checkOutput("bp_stable", {mOValid, mLess, mEqual, mGreater, mOTag}, prevOut);
          if (mOValid && mReadyIn) begin
            checkOutput("bp_tag_order", mOTag, 4'(rxCount));
            checkOutput("bp_flags", {mLess, mEqual, mGreater}, refFlags(rxCount, 3, 0, 8));
            rxCount++;
          end
          prevStall = mOValid && !mReadyIn;
          prevOut = {mOValid, mLess, mEqual, mGreater, mOTag};
          @(posedge clk);
          #1;
        end
      end
    join
    mReadyIn = 1'b1;
    checkOutput("bp_beat_count", rxCount, 6);
    checkOutput("bp_ready_dropped", sawNotReady, 1);

    // Random streaming against the reference model.
    mainMon = 1'b1;
    for (int i = 0; i < 400; i++) begin
      mValid = 1'($urandom_range(0, 1));
      mReadyIn = ($urandom_range(0, 3) != 0);
      mB = 8'($urandom_range(0, 255));
      case ($urandom_range(0, 3))
        0: mA = mB;
        1: mA = {1'($urandom_range(0, 1)), 7'h00};
        default: mA = 8'($urandom_range(0, 255));
      endcase
      if ($urandom_range(0, 7) == 0) mB = {1'($urandom_range(0, 1)), 7'h00};
      mMode = 2'($urandom_range(0, 3));
      mTag = 4'($urandom_range(0, 15));
      tick();
    end
    mValid = 1'b0;
    mReadyIn = 1'b1;
    repeat (4) tick();
    checkOutput("rand_drained", mainQ.size(), 0);
    mainMon = 1'b0;

    // Exhaustive 4-bit sweep on the one- and two-stage instances.
    fork
      runSweep(0);
      runSweep(1);
    join
    checkOutput("sweep_s1_drained", sweepQ0.size(), 0);
    checkOutput("sweep_s2_drained", sweepQ1.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
